cannon_sequencer: RTL and testbench

//   Control and result-drain end of the N x N Cannon PE array. On start it pulses
//   the array load/init strobe, then enables N shift-multiply-accumulate steps.
//   It snapshots all N*N accumulators and streams them out one per beat, row-major,

---
 rtl/cannon_sequencer.sv | 118 +++++++++++
 tb/tb_cannon_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/cannon_sequencer.sv
// Control and result-drain sequencer for an N x N Cannon PE array: load strobe,
// N compute steps, accumulator snapshot, then a row-major valid/ready drain.
module cannon_sequencer #(
    parameter int N  = 4,
    parameter int SW = 8,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [N*N*SW-1:0] s_flat,
    output logic              arr_load,
    output logic              arr_en,
    output logic              busy,
    output logic              done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SW-1:0]     out_data,
    output logic [IW-1:0]     out_row,
    output logic [IW-1:0]     out_col,
    output logic              out_last,
    output logic [2:0]        dbg_state
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LOAD    = 3'd1;
    localparam logic [2:0] COMPUTE = 3'd2;
    localparam logic [2:0] SNAP    = 3'd3;
    localparam logic [2:0] DRAIN   = 3'd4;

    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    logic [2:0]    state;
    logic [IW-1:0] step;
    logic [IW-1:0] row;
    logic [IW-1:0] col;
    logic          done_q;
    logic [SW-1:0] snap [N][N];

    // Handshake: a beat transfers on a rising edge where out_valid & out_ready.
    // out_valid depends only on state, and the beat fields depend only on
    // registered row/col/snapshot, so they hold steady while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            step   <= '0;
            row    <= '0;
            col    <= '0;
            done_q <= 1'b0;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    snap[r][c] <= '0;
                end
            end
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    step  <= '0;
                    state <= COMPUTE;
                end
                COMPUTE: begin
                    if (step == LAST_IDX) begin
                        state <= SNAP;
                    end else begin
                        step <= step + 1'b1;
                    end
                end
                SNAP: begin
                    for (int r = 0; r < N; r++) begin
                        for (int c = 0; c < N; c++) begin
                            snap[r][c] <= s_flat[(r*N+c)*SW +: SW];
                        end
                    end
                    row   <= '0;
                    col   <= '0;
                    state <= DRAIN;
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (col == LAST_IDX) begin
                            col <= '0;
                            if (row == LAST_IDX) begin
                                row    <= '0;
                                state  <= IDLE;
                                done_q <= 1'b1;
                            end else begin
                                row <= row + 1'b1;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        arr_load  = (state == LOAD);
        arr_en    = (state == COMPUTE);
        busy      = (state != IDLE);
        done      = done_q;
        out_valid = (state == DRAIN);
        out_row   = row;
        out_col   = col;
        out_data  = out_valid ? snap[row][col] : '0;
        out_last  = out_valid && (row == LAST_IDX) && (col == LAST_IDX);
        dbg_state = state;
    end

endmodule

// File: tb/tb_cannon_sequencer.sv
// Randomized bench for cannon_sequencer (N=4, SW=8): a cycle-count timeline model
// predicts strobes, and a queue of s_flat fields captured in the snapshot cycle predicts the drain.
module tb_cannon_sequencer;

  localparam int N  = 4;
  localparam int SW = 8;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              out_ready = 1'b0;
  logic [N*N*SW-1:0] s_flat = '0;
  logic              arr_load, arr_en, busy, done, out_valid, out_last;
  logic [SW-1:0]     out_data;
  logic [IW-1:0]     out_row, out_col;
  logic [2:0]        dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [SW-1:0] exp_q[$];

  cannon_sequencer #(.N(N), .SW(SW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .s_flat(s_flat),
    .arr_load(arr_load), .arr_en(arr_en), .busy(busy), .done(done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_last(out_last),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [N*N*SW-1:0] rand_flat();
    logic [N*N*SW-1:0] f;
    for (int i = 0; i < N*N; i++) f[i*SW +: SW] = SW'($urandom_range(0, 255));
    return f;
  endfunction

  function automatic logic [N*N*SW-1:0] grid_flat();
    logic [N*N*SW-1:0] f;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) f[(r*N+c)*SW +: SW] = SW'(16*r + c);
    return f;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_load"}, arr_load, 0);
    check({tag, "_en"}, arr_en, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_row"}, out_row, 0);
    check({tag, "_col"}, out_col, 0);
    check({tag, "_last"}, out_last, 0);
  endtask

  // Entered at a negedge with the DUT idle and start=1; returns at the negedge
  // of the done cycle (or after an abort and reset release).
  // rdy_mode: 0 always ready, 1 toggle with 5-cycle stall at beat 6, 2 random.
  task automatic run(input bit grid, input bit hold, input bit poke,
                     input int rdy_mode, input bit iso, input int abort_beat);
    int  beat = 0;
    int  stall = 0;
    bit  tog = 1'b0;
    bit  aborted = 1'b0;
    bit  rdy;
    exp_q.delete();
    @(posedge clk);
    for (int k = 1; k <= N + 2; k++) begin
      @(negedge clk);
      check("busy", busy, 1);
      check("done", done, 0);
      check("arr_load", arr_load, 32'(k == 1));
      check("arr_en", arr_en, 32'(k >= 2 && k <= N + 1));
      check("valid_early", out_valid, 0);
      start = hold ? 1'b1 : (poke ? 1'($urandom_range(0, 1)) : 1'b0);
      if (k == N + 2) begin
        s_flat = grid ? grid_flat() : rand_flat();
        for (int i = 0; i < N*N; i++) exp_q.push_back(s_flat[i*SW +: SW]);
      end else begin
        s_flat = rand_flat();
      end
    end
    for (int cyc = 0; beat < N*N; cyc++) begin
      if (cyc > 2000) begin
        check("drain_timeout", beat, N*N);
        break;
      end
      @(negedge clk);
      check("valid", out_valid, 1);
      check("data", out_data, exp_q[0]);
      check("row", out_row, beat / N);
      check("col", out_col, beat % N);
      check("last", out_last, 32'(beat == N*N - 1));
      check("busy_drain", busy, 1);
      check("done_drain", done, 0);
      check("en_drain", arr_en, 0);
      if (beat == abort_beat) begin
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        aborted = 1'b1;
        break;
      end
      case (rdy_mode)
        0: rdy = 1'b1;
        1: begin
          if (beat == 6 && stall < 5) begin
            rdy = 1'b0;
            stall++;
          end else begin
            tog = ~tog;
            rdy = tog;
          end
        end
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      start = hold ? 1'b1 : (poke ? 1'($urandom_range(0, 1)) : 1'b0);
      s_flat = iso ? '1 : rand_flat();
      if (rdy) begin
        void'(exp_q.pop_front());
        beat++;
      end
    end
    if (aborted) begin
      repeat (3) begin
        @(negedge clk);
        check("abort_done", done, 0);
        check("abort_busy", busy, 0);
        check("abort_valid", out_valid, 0);
      end
      start = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      check("post_abort_busy", busy, 0);
      check("post_abort_done", done, 0);
    end else begin
      @(negedge clk);
      check("done_pulse", done, 1);
      check("done_busy", busy, 0);
      check("done_valid", out_valid, 0);
      check("done_load", arr_load, 0);
      out_ready = 1'b0;
      start = hold;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_all_zero("reset");
    end
    rst_n = 1'b1;
    run(1, 0, 0, 0, 0, -1);           // plain run with 16*r+c grid
    start = 1'b1;
    run(1, 0, 0, 1, 0, -1);           // toggling ready plus stall on beat (1,2)
    start = 1'b1;
    run(1, 0, 0, 2, 1, -1);           // s_flat forced to 0xFF after snapshot
    start = 1'b1;
    run(0, 0, 1, 2, 0, -1);           // start poked during busy phases
    start = 1'b1;
    run(0, 1, 0, 0, 0, -1);           // start held: next run follows done
    run(0, 0, 0, 2, 0, -1);
    start = 1'b1;
    run(1, 0, 0, 2, 0, 5);            // reset during drain
    start = 1'b1;
    run(1, 0, 0, 0, 0, -1);
    for (int i = 0; i < 3; i++) begin
      start = 1'b1;
      run(0, 0, 1, 2, 1'($urandom_range(0, 1)), -1);
    end
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("final_idle", busy, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
